// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and constants for the hazard sequencer and its comparator.
package hazard_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        HS_RUN      = 2'd0,
        HS_LU_STALL = 2'd1,
        HS_MEM_WAIT = 2'd2,
        HS_FLUSH    = 2'd3
    } hs_state_t;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator between the decode instruction and a load in EX.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    output logic       hz_o
);

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign hz_o = ex_mem_read_i & (ex_rt_i != REG_ZERO) &
                  ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: load-use stall, branch flush and memory-freeze scheduler for the IF..MEM pipeline.
// Defining HAZARD_SEQ_PERF_EN adds saturating stall/flush performance counters.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_flush,
    output logic        pipe_freeze,
    output logic [1:0]  state_o,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    // cnt holds the number of extra cycles still owed after the current one
    localparam logic [2:0] LU_CNT = (LU_STALL_CYCLES > 1) ? 3'(LU_STALL_CYCLES - 2) : 3'd0;
    localparam logic [2:0] FL_CNT = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

    hs_state_t  state_q, state_d;
    hs_state_t  saved_q, saved_d;
    hs_state_t  eff;
    logic [2:0] cnt_q, cnt_d;
    logic       hz;
    logic       pc_w, ifid_w, ifid_f, idex_b, exmem_f, freeze;

    hazard_detect u_detect (
        .ex_mem_read_i (ex_mem_read),
        .ex_rt_i       (ex_rt),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rt_i  (id_uses_rt),
        .hz_o          (hz)
    );

    // MEM_WAIT behaves as the state it interrupted once memory is ready
    assign eff = (state_q == HS_MEM_WAIT) ? saved_q : state_q;

    // state, resume-state and down-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HS_RUN;
            saved_q <= HS_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    // prioritised next-state and Mealy output decode: mem_busy > branch > load-use
    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        cnt_d   = cnt_q;
        pc_w    = 1'b1;
        ifid_w  = 1'b1;
        ifid_f  = 1'b0;
        idex_b  = 1'b0;
        exmem_f = 1'b0;
        freeze  = 1'b0;
        if (mem_busy) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            freeze  = 1'b1;
            saved_d = eff;
            state_d = HS_MEM_WAIT;
        end else if (branch_taken) begin
            ifid_f  = 1'b1;
            idex_b  = 1'b1;
            exmem_f = 1'b1;
            state_d = (FLUSH_CYCLES > 1) ? HS_FLUSH : HS_RUN;
            cnt_d   = FL_CNT;
        end else if (eff == HS_FLUSH) begin
            ifid_f  = 1'b1;
            state_d = (cnt_q == 3'd0) ? HS_RUN : HS_FLUSH;
            cnt_d   = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
        end else if (eff == HS_LU_STALL) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_b  = 1'b1;
            state_d = (cnt_q == 3'd0) ? HS_RUN : HS_LU_STALL;
            cnt_d   = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
        end else if (hz) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_b  = 1'b1;
            state_d = (LU_STALL_CYCLES > 1) ? HS_LU_STALL : HS_RUN;
            cnt_d   = LU_CNT;
        end else begin
            state_d = HS_RUN;
        end
    end

    // outputs are forced low while reset is asserted
    assign pc_write    = rst_n & pc_w;
    assign ifid_write  = rst_n & ifid_w;
    assign ifid_flush  = rst_n & ifid_f;
    assign idex_bubble = rst_n & idex_b;
    assign exmem_flush = rst_n & exmem_f;
    assign pipe_freeze = rst_n & freeze;
    assign state_o     = state_q;

`ifdef HAZARD_SEQ_PERF_EN
    logic [31:0] stall_q, flush_q;

    // saturating counts of PC-held cycles and IF/ID flush cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (!pc_write && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
            if (ifid_flush && flush_q != 32'hFFFF_FFFF) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;
`else
    assign stall_count = 32'd0;
    assign flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed checks of two sequencer configurations (LU=1/FLUSH=3 and LU=3/FLUSH=1).
module tb_hazard_sequencer;

    // output vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_freeze}
    localparam logic [5:0] RUNO = 6'b110000;
    localparam logic [5:0] STL  = 6'b000100;
    localparam logic [5:0] FRZ  = 6'b000001;
    localparam logic [5:0] BR   = 6'b111110;
    localparam logic [5:0] FL   = 6'b111000;
    localparam logic [5:0] ZRO  = 6'b000000;
`ifdef HAZARD_SEQ_PERF_EN
    localparam logic [31:0] EXP_S = 32'd1;
    localparam logic [31:0] EXP_F = 32'd3;
`else
    localparam logic [31:0] EXP_S = 32'd0;
    localparam logic [31:0] EXP_F = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mr = 1'b0, urt = 1'b0, bt = 1'b0, mb = 1'b0;
    logic [4:0] ert = '0, rs = '0, rt = '0;
    int total = 0;
    int bad = 0;

    logic pw_a, iw_a, if_a, ib_a, ef_a, pf_a, pw_b, iw_b, if_b, ib_b, ef_b, pf_b;
    logic [1:0] sa, sb;
    logic [31:0] sc_a, fc_a, sc_b, fc_b;
    logic [5:0] oa, ob;

    assign oa = {pw_a, iw_a, if_a, ib_a, ef_a, pf_a};
    assign ob = {pw_b, iw_b, if_b, ib_b, ef_b, pf_b};

    always #5 clk = ~clk;

    hazard_sequencer #(.LU_STALL_CYCLES(1), .FLUSH_CYCLES(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs(rs), .id_rt(rt), .id_uses_rt(urt),
        .ex_mem_read(mr), .ex_rt(ert), .branch_taken(bt), .mem_busy(mb),
        .pc_write(pw_a), .ifid_write(iw_a), .ifid_flush(if_a), .idex_bubble(ib_a),
        .exmem_flush(ef_a), .pipe_freeze(pf_a), .state_o(sa),
        .stall_count(sc_a), .flush_count(fc_a)
    );

    hazard_sequencer #(.LU_STALL_CYCLES(3), .FLUSH_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs(rs), .id_rt(rt), .id_uses_rt(urt),
        .ex_mem_read(mr), .ex_rt(ert), .branch_taken(bt), .mem_busy(mb),
        .pc_write(pw_b), .ifid_write(iw_b), .ifid_flush(if_b), .idex_bubble(ib_b),
        .exmem_flush(ef_b), .pipe_freeze(pf_b), .state_o(sb),
        .stall_count(sc_b), .flush_count(fc_b)
    );

    // apply one cycle of inputs at the falling edge and settle before sampling
    task automatic drv(input logic m, input logic [4:0] e, r, t, input logic u, b, k);
        @(negedge clk);
        mr = m; ert = e; rs = r; rt = t; urt = u; bt = b; mb = k;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        total++; if (oa !== ZRO) begin bad++; $display("FAIL rst_low_a got=%b want=%b", oa, ZRO); end
        total++; if (ob !== ZRO) begin bad++; $display("FAIL rst_low_b got=%b want=%b", ob, ZRO); end
        total++; if (sa !== 2'd0) begin bad++; $display("FAIL rst_low_state got=%0d want=0", sa); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (oa !== RUNO) begin bad++; $display("FAIL rst_rel_a got=%b want=%b", oa, RUNO); end
        total++; if (sc_a !== 32'd0) begin bad++; $display("FAIL rst_stall_cnt got=%0d want=0", sc_a); end
        total++; if (fc_a !== 32'd0) begin bad++; $display("FAIL rst_flush_cnt got=%0d want=0", fc_a); end
    endtask

    task automatic test_load_use_rs;
        drv(1, 8, 8, 0, 0, 0, 0);
        total++; if (oa !== STL) begin bad++; $display("FAIL lu_rs_c0_a got=%b want=%b", oa, STL); end
        total++; if (ob !== STL) begin bad++; $display("FAIL lu_rs_c0_b got=%b want=%b", ob, STL); end
        idle(1);
        total++; if (oa !== RUNO) begin bad++; $display("FAIL lu_rs_c1_a got=%b want=%b", oa, RUNO); end
        total++; if (sa !== 2'd0) begin bad++; $display("FAIL lu_rs_c1_sa got=%0d want=0", sa); end
        total++; if (ob !== STL) begin bad++; $display("FAIL lu_rs_c1_b got=%b want=%b", ob, STL); end
        total++; if (sb !== 2'd1) begin bad++; $display("FAIL lu_rs_c1_sb got=%0d want=1", sb); end
        idle(1);
        total++; if (ob !== STL) begin bad++; $display("FAIL lu_rs_c2_b got=%b want=%b", ob, STL); end
        idle(1);
        total++; if (ob !== RUNO) begin bad++; $display("FAIL lu_rs_c3_b got=%b want=%b", ob, RUNO); end
        total++; if (sb !== 2'd0) begin bad++; $display("FAIL lu_rs_c3_sb got=%0d want=0", sb); end
    endtask

    task automatic test_load_use_rt;
        drv(1, 9, 3, 9, 0, 0, 0);
        total++; if (oa !== RUNO) begin bad++; $display("FAIL lu_rt_unused_a got=%b want=%b", oa, RUNO); end
        drv(1, 9, 3, 9, 1, 0, 0);
        total++; if (oa !== STL) begin bad++; $display("FAIL lu_rt_used_a got=%b want=%b", oa, STL); end
        idle(1);
        total++; if (oa !== RUNO) begin bad++; $display("FAIL lu_rt_after_a got=%b want=%b", oa, RUNO); end
        idle(2);
    endtask

    task automatic test_zero_reg;
        drv(1, 0, 0, 0, 1, 0, 0);
        total++; if (oa !== RUNO) begin bad++; $display("FAIL zero_reg_a got=%b want=%b", oa, RUNO); end
        total++; if (ob !== RUNO) begin bad++; $display("FAIL zero_reg_b got=%b want=%b", ob, RUNO); end
    endtask

    task automatic test_branch;
        drv(0, 0, 0, 0, 0, 1, 0);
        total++; if (oa !== BR) begin bad++; $display("FAIL br_c0_a got=%b want=%b", oa, BR); end
        total++; if (ob !== BR) begin bad++; $display("FAIL br_c0_b got=%b want=%b", ob, BR); end
        idle(1);
        total++; if (oa !== FL) begin bad++; $display("FAIL br_c1_a got=%b want=%b", oa, FL); end
        total++; if (sa !== 2'd3) begin bad++; $display("FAIL br_c1_sa got=%0d want=3", sa); end
        total++; if (ob !== RUNO) begin bad++; $display("FAIL br_c1_b got=%b want=%b", ob, RUNO); end
        drv(1, 8, 8, 0, 0, 0, 0);
        total++; if (oa !== FL) begin bad++; $display("FAIL br_c2_hz_a got=%b want=%b", oa, FL); end
        total++; if (ob !== STL) begin bad++; $display("FAIL br_c2_hz_b got=%b want=%b", ob, STL); end
        idle(1);
        total++; if (oa !== RUNO) begin bad++; $display("FAIL br_c3_a got=%b want=%b", oa, RUNO); end
        total++; if (sa !== 2'd0) begin bad++; $display("FAIL br_c3_sa got=%0d want=0", sa); end
        idle(3);
    endtask

    task automatic test_mem_busy_mid_stall;
        drv(1, 8, 8, 0, 0, 0, 0);
        total++; if (ob !== STL) begin bad++; $display("FAIL mb_c0_b got=%b want=%b", ob, STL); end
        for (int i = 0; i < 4; i++) begin
            drv(1, 8, 8, 0, 0, 0, 1);
            total++; if (ob !== FRZ) begin bad++; $display("FAIL mb_frz%0d_b got=%b want=%b", i, ob, FRZ); end
            if (i == 1) begin
                total++; if (sb !== 2'd2) begin bad++; $display("FAIL mb_wait_sb got=%0d want=2", sb); end
                total++; if (oa !== FRZ) begin bad++; $display("FAIL mb_frz_a got=%b want=%b", oa, FRZ); end
            end
        end
        drv(1, 8, 8, 0, 0, 0, 0);
        total++; if (ob !== STL) begin bad++; $display("FAIL mb_resume1_b got=%b want=%b", ob, STL); end
        drv(1, 8, 8, 0, 0, 0, 0);
        total++; if (ob !== STL) begin bad++; $display("FAIL mb_resume2_b got=%b want=%b", ob, STL); end
        idle(1);
        total++; if (ob !== RUNO) begin bad++; $display("FAIL mb_done_b got=%b want=%b", ob, RUNO); end
        total++; if (sb !== 2'd0) begin bad++; $display("FAIL mb_done_sb got=%0d want=0", sb); end
        total++; if (oa !== RUNO) begin bad++; $display("FAIL mb_done_a got=%b want=%b", oa, RUNO); end
    endtask

    task automatic test_branch_and_hz;
        drv(1, 8, 8, 0, 0, 1, 0);
        total++; if (oa !== BR) begin bad++; $display("FAIL brhz_c0_a got=%b want=%b", oa, BR); end
        total++; if (ob !== BR) begin bad++; $display("FAIL brhz_c0_b got=%b want=%b", ob, BR); end
        idle(1);
        total++; if (ob !== RUNO) begin bad++; $display("FAIL brhz_c1_b got=%b want=%b", ob, RUNO); end
        total++; if (sb !== 2'd0) begin bad++; $display("FAIL brhz_c1_sb got=%0d want=0", sb); end
        total++; if (oa !== FL) begin bad++; $display("FAIL brhz_c1_a got=%b want=%b", oa, FL); end
        idle(2);
        total++; if (oa !== RUNO) begin bad++; $display("FAIL brhz_c3_a got=%b want=%b", oa, RUNO); end
    endtask

    task automatic test_branch_aborts_stall;
        drv(1, 8, 8, 0, 0, 0, 0);
        total++; if (ob !== STL) begin bad++; $display("FAIL abort_c0_b got=%b want=%b", ob, STL); end
        drv(0, 0, 0, 0, 0, 1, 0);
        total++; if (ob !== BR) begin bad++; $display("FAIL abort_c1_b got=%b want=%b", ob, BR); end
        idle(1);
        total++; if (ob !== RUNO) begin bad++; $display("FAIL abort_c2_b got=%b want=%b", ob, RUNO); end
        total++; if (sb !== 2'd0) begin bad++; $display("FAIL abort_c2_sb got=%0d want=0", sb); end
        idle(2);
        total++; if (oa !== RUNO) begin bad++; $display("FAIL abort_c4_a got=%b want=%b", oa, RUNO); end
    endtask

    task automatic test_reset_in_flush;
        drv(0, 0, 0, 0, 0, 1, 0);
        total++; if (oa !== BR) begin bad++; $display("FAIL rf_c0_a got=%b want=%b", oa, BR); end
        @(negedge clk);
        rst_n = 1'b0; bt = 1'b0;
        #1;
        total++; if (oa !== ZRO) begin bad++; $display("FAIL rf_rst_a got=%b want=%b", oa, ZRO); end
        total++; if (ob !== ZRO) begin bad++; $display("FAIL rf_rst_b got=%b want=%b", ob, ZRO); end
        total++; if (sa !== 2'd0) begin bad++; $display("FAIL rf_rst_sa got=%0d want=0", sa); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (oa !== RUNO) begin bad++; $display("FAIL rf_rel_a got=%b want=%b", oa, RUNO); end
        total++; if (sa !== 2'd0) begin bad++; $display("FAIL rf_rel_sa got=%0d want=0", sa); end
        total++; if (sc_a !== 32'd0) begin bad++; $display("FAIL rf_rel_stall_cnt got=%0d want=0", sc_a); end
        total++; if (fc_a !== 32'd0) begin bad++; $display("FAIL rf_rel_flush_cnt got=%0d want=0", fc_a); end
    endtask

    task automatic test_counters;
        drv(1, 8, 8, 0, 0, 0, 0);
        idle(1);
        drv(0, 0, 0, 0, 0, 1, 0);
        idle(3);
        total++; if (oa !== RUNO) begin bad++; $display("FAIL cnt_end_a got=%b want=%b", oa, RUNO); end
        total++; if (sc_a !== EXP_S) begin bad++; $display("FAIL cnt_stall got=%0d want=%0d", sc_a, EXP_S); end
        total++; if (fc_a !== EXP_F) begin bad++; $display("FAIL cnt_flush got=%0d want=%0d", fc_a, EXP_F); end
    endtask

    initial begin
        test_reset();
        test_load_use_rs();
        test_load_use_rt();
        test_zero_reg();
        test_branch();
        test_mem_busy_mid_stall();
        test_branch_and_hz();
        test_branch_aborts_stall();
        test_reset_in_flush();
        test_counters();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline scheduler for the IF/ID register, decode stage and downstream pipeline registers.
- Detects load-use hazards between the instruction in decode and a load in EX, and inserts stall cycles.
- Flushes wrong-path instructions on a taken branch resolved in MEM.
- Freezes the whole pipeline while data memory reports busy.
- Drives write-enables/flushes for PC, IF/ID, ID/EX and EX/MEM; sits beside the decode stage.

Parameters:
- LU_STALL_CYCLES, 1, bubbles per load-use hazard (2 when EX forwarding is absent); legal 1..7.
- FLUSH_CYCLES, 1, cycles IF/ID is flushed after a taken branch (>1 covers fetch latency); legal 1..7.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  5  rs field of the instruction in decode (bits 25:21).
- id_rt  in  5  rt field of the instruction in decode (bits 20:16).
- id_uses_rt  in  1  decode instruction reads rt (R-type, beq, sw).
- ex_mem_read  in  1  MemRead of the instruction in EX.
- ex_rt  in  5  destination rt of the instruction in EX.
- branch_taken  in  1  branch resolved taken in MEM this cycle.
- mem_busy  in  1  data memory not ready; whole pipeline must hold.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a nop.
- idex_bubble  out  1  ID/EX loads zeroed control.
- exmem_flush  out  1  EX/MEM loads zeroed control.
- pipe_freeze  out  1  ID/EX, EX/MEM, MEM/WB hold their contents.
- state_o  out  2  current state, for debug.
- stall_count  out  32  performance counter (optional feature).
- flush_count  out  32  performance counter (optional feature).

Behaviour:
- States:
  - RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH=3.
  - Internal 3-bit down-counter cnt.
  - Reset: state=RUN, cnt=0.
  - While rst_n=0, all outputs are 0.
- Outputs are Mealy: a function of state, cnt and the current inputs.
- Default (RUN, no event): pc_write=1, ifid_write=1; all flush/bubble/freeze outputs 0.
- Hazard condition: hz = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Priority in any state: mem_busy > branch_taken > hz.
- mem_busy=1:
  - pipe_freeze=1, pc_write=0, ifid_write=0; flush and bubble outputs 0.
  - state is saved and cnt holds.
  - Next state is MEM_WAIT, with the state to resume stored.
- MEM_WAIT with mem_busy=0: apply the rules of the saved state in the same cycle. There is no dead cycle.
- branch_taken (mem_busy=0):
  - In the branch cycle: pc_write=1, ifid_flush=1, idex_bubble=1, exmem_flush=1, ifid_write=1.
  - If FLUSH_CYCLES>1: go to FLUSH with cnt=FLUSH_CYCLES-2; otherwise stay in RUN.
  - A branch aborts any LU_STALL in progress.
- FLUSH:
  - Outputs: pc_write=1, ifid_write=1, ifid_flush=1; other outputs 0.
  - If cnt==0, go to RUN; else cnt decrements.
  - hz is ignored in FLUSH.
- hz in RUN:
  - Outputs: pc_write=0, ifid_write=0, idex_bubble=1.
  - If LU_STALL_CYCLES>1: go to LU_STALL with cnt=LU_STALL_CYCLES-2.
- LU_STALL:
  - Outputs are the same as the hz response.
  - If cnt==0, go to RUN; else cnt decrements.
- A reset asserted mid-stall or mid-flush returns to RUN immediately; no partial state is retained.

Optional Feature:
- Macro HAZARD_SEQ_PERF_EN.
- With the macro:
  - stall_count increments on every cycle where pc_write=0 and rst_n=1.
  - flush_count increments on every cycle where ifid_flush=1.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Without the macro: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- Shared package hazard_pkg holds:
  - the state encoding constants HS_RUN/HS_LU_STALL/HS_MEM_WAIT/HS_FLUSH;
  - the 2-bit state typedef;
  - REG_ZERO=5'd0.
- Sub-module hazard_detect: the purely combinational hz comparator. It is reused by a future forwarding unit.

Test Plan:
- Load-use on rs:
  - Stimulus: ex_mem_read=1, ex_rt=5'd8, id_rs=8, LU_STALL_CYCLES=1.
  - Response: one cycle with pc_write=0, ifid_write=0, idex_bubble=1, then RUN outputs.
- Zero register: ex_rt=0, id_rs=0, ex_mem_read=1 -> no stall; pc_write=1.
- Branch with FLUSH_CYCLES=3: branch_taken pulse -> ifid_flush=1 for 3 consecutive cycles; idex_bubble and exmem_flush=1 only in the first cycle.
- mem_busy mid-stall:
  - Stimulus: LU_STALL_CYCLES=3; mem_busy high for 4 cycles during the second stall cycle.
  - Response: pipe_freeze=1 for 4 cycles, then the remaining 2 stall cycles complete.
- Simultaneous branch_taken and hz -> flush response only; no LU_STALL entry.
- Reset in FLUSH:
  - Stimulus: rst_n low at the second flush cycle.
  - Response: all outputs 0 immediately; after release, state_o=0 and pc_write=1.
  - With HAZARD_SEQ_PERF_EN, the counters read 0.
